// File: rtl/dcache_wb_if.sv
// Bundles the pipeline-side request port and the physical-memory line port of dcache_wb.
// slave = cache view, master = environment view (pipeline + memory).
interface dcache_wb_if;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 256-bit line bursts.
// Optional hit/miss counters are enabled with `define DCACHE_PERF_EN.
module dcache_wb #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic        clk,
  input  logic        rst,
  dcache_wb_if.slave  bus
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);
  localparam int LINES  = 2 ** S_INDEX;
  localparam int TAG_W  = 32 - S_INDEX - S_OFFSET;
  localparam int LINE_W = 8 << S_OFFSET;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t               state, state_d;
  logic [LINE_W-1:0]    data_q [LINES];
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;

  logic [S_INDEX-1:0]   index;
  logic [TAG_W-1:0]     tag;
  logic [S_OFFSET-3:0]  word;
  logic                 req;
  logic                 hit;
  logic                 wr_hit;
  logic                 fill_done;
  logic                 miss_start;
  logic                 unused_addr_bits;

  assign index            = bus.mem_address[S_OFFSET +: S_INDEX];
  assign tag              = bus.mem_address[31 -: TAG_W];
  assign word             = bus.mem_address[S_OFFSET-1:2];
  assign unused_addr_bits = ^bus.mem_address[1:0];
  assign req              = bus.mem_read | bus.mem_write;
  assign hit              = valid_q[index] && (tag_q[index] == tag);
  assign wr_hit           = (state == IDLE) && bus.mem_write && hit;
  assign fill_done        = (state == ALLOCATE) && bus.pmem_resp;
  assign miss_start       = (state == IDLE) && req && !hit;

  // NOTE: every output and state_d gets a default first so no path leaves a latch.
  always_comb begin
    state_d          = state;
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = data_q[index][{word, 5'b0} +: 32];
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (hit) bus.mem_resp = 1'b1;
          else if (valid_q[index] && dirty_q[index]) state_d = WRITEBACK;
          else state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_q[index], index, {S_OFFSET{1'b0}}};
        bus.pmem_wdata   = data_q[index];
        if (bus.pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {bus.mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
        if (bus.pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state <= state_d;
      if (fill_done) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  // NOTE: data and tag arrays carry no reset; cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[index] <= bus.pmem_rdata;
      tag_q[index]  <= tag;
    end else if (wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_byte_enable[b])
          data_q[index][{word, 2'(b), 3'b0} +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (bus.mem_resp) perf_hits <= perf_hits + 32'd1;
      if (miss_start)   perf_misses <= perf_misses + 32'd1;
    end
  end
`else
  logic unused_miss_start;
  assign unused_miss_start = miss_start;
`endif

  // The requester must hold a request unchanged until it sees mem_resp.
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (req && !bus.mem_resp) |=> ($stable(bus.mem_address) && $stable(bus.mem_read) &&
      $stable(bus.mem_write) && $stable(bus.mem_byte_enable) && $stable(bus.mem_wdata)));

  a_pmem_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.pmem_read && bus.pmem_write));

endmodule

// File: tb/tb_dcache_wb.sv
// Randomized self-checking bench for dcache_wb: cache/memory reference model plus memory responder.
// Counter checks are compiled in when DCACHE_PERF_EN is defined.
module tb_dcache_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  dcache_wb_if bus();

`ifdef DCACHE_PERF_EN
  logic [31:0] perf_hits, perf_misses;
  dcache_wb dut (.clk(clk), .rst(rst), .bus(bus), .perf_hits(perf_hits), .perf_misses(perf_misses));
`else
  dcache_wb dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cache contents per set and a sparse backing memory of lines.
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [23:0]  m_tag   [8];
  logic [255:0] m_data  [8];
  logic [255:0] mem_model [logic [26:0]];
  int           exp_hits, exp_misses;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] get_line(input logic [26:0] la);
    logic [255:0] v;
    if (!mem_model.exists(la)) begin
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      mem_model[la] = v;
    end
    return mem_model[la];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  task automatic idle_inputs();
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_byte_enable = '0;
    bus.mem_wdata       = '0;
    bus.pmem_resp       = 1'b0;
    bus.pmem_rdata      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst_mem_resp", bus.mem_resp, 1'b0);
    check("rst_pmem_read", bus.pmem_read, 1'b0);
    check("rst_pmem_write", bus.pmem_write, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One memory burst; called at a negedge, returns at a later negedge. The DUT must hold the
  // request from the first cycle until the randomly delayed pmem_resp.
  task automatic pmem_txn(input bit is_wb, input logic [31:0] exp_addr,
                          input logic [255:0] exp_wdata, input logic [255:0] fill);
    int lat;
    lat = $urandom_range(0, 3);
    for (int c = 0; c <= lat; c++) begin
      #1;
      check(is_wb ? "wb_pmem_write" : "fill_pmem_read",
            is_wb ? bus.pmem_write : bus.pmem_read, 1'b1);
      check("pmem_exclusive", bus.pmem_read & bus.pmem_write, 1'b0);
      check("burst_no_resp", bus.mem_resp, 1'b0);
      if (c == 0) begin
        check(is_wb ? "wb_addr" : "fill_addr", bus.pmem_address, exp_addr);
        if (is_wb) check("wb_data", bus.pmem_wdata, exp_wdata);
      end
      if (c == lat) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = is_wb ? $urandom : fill;
      end
      @(posedge clk);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
    end
  endtask

  // Full access from request to mem_resp; starts and ends at a negedge with the request dropped.
  task automatic access(input logic [31:0] a, input bit rd, input bit wr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rdata);
    int           idx, w;
    logic [23:0]  tg;
    logic [26:0]  la;
    logic [255:0] ln;
    idx = int'(a[7:5]);
    w   = int'(a[4:2]);
    tg  = a[31:8];
    la  = a[31:5];
    bus.mem_address     = a;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      #1;
      check("miss_no_resp", bus.mem_resp, 1'b0);
      check("miss_pmem_idle", {bus.pmem_read, bus.pmem_write}, 2'b00);
      exp_misses++;
      @(posedge clk);
      @(negedge clk);
      if (m_valid[idx] && m_dirty[idx]) begin
        pmem_txn(1'b1, {m_tag[idx], 3'(idx), 5'b0}, m_data[idx], '0);
        mem_model[{m_tag[idx], 3'(idx)}] = m_data[idx];
      end
      ln = get_line(la);
      pmem_txn(1'b0, {la, 5'b0}, '0, ln);
      m_data[idx]  = ln;
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    #1;
    check("hit_resp", bus.mem_resp, 1'b1);
    check("hit_no_pmem", {bus.pmem_read, bus.pmem_write}, 2'b00);
    rdata = bus.mem_rdata;
    exp_hits++;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_data[idx][32*w + 8*b +: 8] = wd[8*b +: 8];
      m_dirty[idx] = 1'b1;
    end else begin
      check("rdata", rdata, m_data[idx][32*w +: 32]);
    end
    @(posedge clk);
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    idle_inputs();
    do_reset();

    // Scenario 1/2/5: fill of known words, byte merge, read+write treated as write.
    mem_model[27'h2] = {8{32'h11111111}};
    access(32'h40, 1, 0, 4'h0, 32'h0, r);
    check("t1_fill_word0", r, 32'h11111111);
    access(32'h40, 1, 0, 4'h0, 32'h0, r);
    check("t1_rehit", r, 32'h11111111);
`ifdef DCACHE_PERF_EN
    check("t6_perf_misses", perf_misses, 32'd1);
    check("t6_perf_hits", perf_hits, 32'd2);
`endif
    access(32'h44, 0, 1, 4'b0011, 32'hDEADBEEF, r);
    access(32'h44, 1, 0, 4'h0, 32'h0, r);
    check("t2_merge", r, 32'h1111BEEF);
    access(32'h48, 1, 1, 4'hF, 32'h5, r);
    access(32'h48, 1, 0, 4'h0, 32'h0, r);
    check("t5_rw_as_write", r, 32'h5);

    // Scenario 3: dirty victim written back before the conflicting fill.
    access(32'h140, 1, 0, 4'h0, 32'h0, r);
    check("t3_victim_mem", mem_model[27'h2][95:32], {32'h5, 32'h1111BEEF});

    // Pulse of pmem_resp while idle is ignored.
    #1;
    bus.pmem_resp = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    check("stray_pmem_resp", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 3'b000);
    @(negedge clk);

    // Scenario 4: reset in the middle of a fill.
    do_reset();
    bus.mem_address = 32'h40;
    bus.mem_read    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t4_alloc_read", bus.pmem_read, 1'b1);
    bus.pmem_resp = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("t4_rst_pmem_read", bus.pmem_read, 1'b0);
    check("t4_rst_mem_resp", bus.mem_resp, 1'b0);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    access(32'h40, 1, 0, 4'h0, 32'h0, r);
`ifdef DCACHE_PERF_EN
    check("t4_perf_misses", perf_misses, 32'd1);
`endif

    // Randomized traffic over 4 tags x 8 sets to exercise hits, clean and dirty evictions.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int op;
      a  = {22'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      access(a, op != 1, op != 0, 4'($urandom), $urandom, r);
      if ($urandom_range(0, 3) == 0) begin
        #1;
        check("gap_idle", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 3'b000);
        @(negedge clk);
      end
    end
`ifdef DCACHE_PERF_EN
    check("perf_hits_final", perf_hits, 32'(exp_hits));
    check("perf_misses_final", perf_misses, 32'(exp_misses));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
